// File: rtl/dec_stream_ctrl_pkg.sv
// dec_pkg: shared types and constants for the extended-Hamming (8,4) stream controller
package dec_pkg;

    localparam int DATA_W = 4;
    localparam int CW_W   = 8;

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'b00,
        ST_CORR   = 2'b01,
        ST_UNCORR = 2'b10,
        ST_DET    = 2'b11
    } dec_status_t;

    // codeword bit in error for each syndrome value, indexed by syn[2:0]
    localparam logic [7:0][2:0] SYN_BIT = {
        3'd0, 3'd3, 3'd2, 3'd7, 3'd1, 3'd6, 3'd5, 3'd4
    };

endpackage

// File: rtl/dec_mat_multiplier_8bit.sv
// dec_mat_multiplier_8bit: GF(2) product of the (8,4) parity-check matrix with a codeword
module dec_mat_multiplier_8bit (
    input  logic [7:0] data_in,
    output logic [3:0] mul_result
);

    // rows 3..1 give the syndrome, row 0 is the overall parity check
    localparam logic [3:0][7:0] H = {8'h8D, 8'h4B, 8'h27, 8'hFF};

    for (genvar i = 0; i < 4; i++) begin : g_row
        assign mul_result[i] = ^(H[i] & data_in);
    end

endmodule

// File: rtl/dec_stream_ctrl.sv
// dec_stream_ctrl: two-stage valid/ready SEC-DED decoder with saturating error counters
module dec_stream_ctrl
    import dec_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   codeword_in,
    input  logic              correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   out_codeword,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_corrected,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    logic [3:0]      mul_result;
    logic [2:0]      syn, s1_syn;
    logic            par, s1_par, s1_ce, s1_valid, s2_valid, s2_adv, in_fire, out_fire;
    logic [CW_W-1:0] s1_cw, fix_cw;
    dec_status_t     fix_st, st;

    dec_mat_multiplier_8bit u_mul (
        .data_in    (codeword_in),
        .mul_result (mul_result)
    );

    assign syn       = mul_result[3:1];
    assign par       = mul_result[0];
    assign s2_adv    = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s2_valid && out_ready;
    assign out_valid = s2_valid;
    assign out_data  = out_codeword[DATA_W-1:0];
    assign out_status = st;

    // S1 occupancy: filled on input handshake, emptied when its word moves to S2
    always_ff @(posedge clk) begin
        if (rst)
            s1_valid <= 1'b0;
        else if (in_fire)
            s1_valid <= 1'b1;
        else if (s2_adv)
            s1_valid <= 1'b0;
    end

    // S1 payload: codeword, syndrome and the correction mode in force at capture
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_cw  <= codeword_in;
            s1_syn <= syn;
            s1_par <= par;
            s1_ce  <= correct_en;
        end
    end

    // odd overall parity means a single error; even parity with a syndrome means two
    always_comb begin
        fix_st = s1_par ? (s1_ce ? ST_CORR : ST_DET) : (s1_syn != 3'd0 ? ST_UNCORR : ST_CLEAN);
        fix_cw = (s1_par && s1_ce) ? s1_cw ^ (CW_W'(1) << SYN_BIT[s1_syn]) : s1_cw;
    end

    // S2 output register: loads on advance, holds under backpressure, empties on a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            out_codeword <= '0;
            st           <= ST_CLEAN;
        end else if (s2_adv) begin
            s2_valid     <= 1'b1;
            out_codeword <= fix_cw;
            st           <= fix_st;
        end else if (out_ready) begin
            s2_valid     <= 1'b0;
        end
    end

    // saturating counters on delivered words; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_corrected <= '0;
            cnt_uncorr    <= '0;
        end else if (out_fire) begin
            if (st[0] && cnt_corrected != '1)
                cnt_corrected <= cnt_corrected + CNT_W'(1);
            if (st == ST_UNCORR && cnt_uncorr != '1)
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dec_stream_ctrl.sv
// tb_dec_stream_ctrl: directed and randomized checks against a nearest-codeword decoder model
module tb_dec_stream_ctrl;

    typedef struct {
        logic [7:0] cw;
        logic [1:0] st;
        logic [3:0] data;
        int         cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, in_valid = 1'b0, correct_en = 1'b1, out_ready = 1'b1, clr_cnt = 1'b0;
    logic [7:0]  codeword_in = 8'h00;
    logic        in_ready, out_valid;
    logic [7:0]  out_codeword;
    logic [3:0]  out_data;
    logic [1:0]  out_status;
    logic [15:0] cnt_corrected, cnt_uncorr;
    logic        n_in_ready, n_out_valid;
    logic [7:0]  n_out_codeword;
    logic [3:0]  n_out_data;
    logic [1:0]  n_out_status;
    logic [1:0]  n_cnt_corrected, n_cnt_uncorr;

    int n_chk = 0, n_fail = 0, cyc = 0, in_cnt = 0, stall_cnt = 0, m_corr = 0, m_unc = 0;
    rec_t exp_q[$], ref_q[$], got_q[$];
    int   in_cyc_q[$];

    dec_stream_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .codeword_in(codeword_in), .correct_en(correct_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_codeword(out_codeword), .out_data(out_data),
        .out_status(out_status), .clr_cnt(clr_cnt), .cnt_corrected(cnt_corrected),
        .cnt_uncorr(cnt_uncorr)
    );

    dec_stream_ctrl #(.CNT_W(2)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .codeword_in(codeword_in), .correct_en(correct_en), .out_valid(n_out_valid),
        .out_ready(out_ready), .out_codeword(n_out_codeword), .out_data(n_out_data),
        .out_status(n_out_status), .clr_cnt(clr_cnt), .cnt_corrected(n_cnt_corrected),
        .cnt_uncorr(n_cnt_uncorr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // systematic encoder: three Hamming parity bits, then overall parity, then data
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [2:0] p;
        p[2] = d[3] ^ d[2] ^ d[0];
        p[1] = d[3] ^ d[1] ^ d[0];
        p[0] = d[2] ^ d[1] ^ d[0];
        return {p, ^{p, d}, d};
    endfunction

    // decode by Hamming distance to the 16 valid codewords
    function automatic rec_t decode(input logic [7:0] cw, input logic ce);
        rec_t r;
        int best = 9;
        logic [7:0] near = 8'h00;
        for (int d = 0; d < 16; d++)
            if ($countones(cw ^ encode(4'(d))) < best) begin
                best = $countones(cw ^ encode(4'(d)));
                near = encode(4'(d));
            end
        r.cw = cw;
        if (best == 0)
            r.st = 2'b00;
        else if (best == 1) begin
            r.st = ce ? 2'b01 : 2'b11;
            r.cw = ce ? near : cw;
        end else
            r.st = 2'b10;
        r.data = r.cw[3:0];
        r.cyc = 0;
        return r;
    endfunction

    function automatic logic [1:0] sat3(input int v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    // one clock: observe handshakes mid-cycle, update the model, then step past the edge
    task automatic tick();
        rec_t e, g;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            m_corr = 0;
            m_unc = 0;
        end else begin
            if (out_valid && out_ready) begin
                g.cw = out_codeword; g.st = out_status; g.data = out_data; g.cyc = cyc;
                got_q.push_back(g);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    ref_q.push_back(e);
                    if (e.st[0]) m_corr++;
                    if (e.st == 2'b10) m_unc++;
                end
            end
            if (clr_cnt) begin
                m_corr = 0;
                m_unc = 0;
            end
            if (in_valid && in_ready) begin
                e = decode(codeword_in, correct_en);
                e.cyc = cyc;
                exp_q.push_back(e);
                in_cyc_q.push_back(cyc);
                in_cnt++;
            end
            if (in_valid && !in_ready) stall_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] cw, input logic ce);
        int n;
        n = in_cnt;
        in_valid = 1'b1;
        codeword_in = cw;
        correct_en = ce;
        for (int k = 0; k < 50 && in_cnt == n; k++) tick();
        in_valid = 1'b0;
        n_chk++;
        if (in_cnt == n) begin
            n_fail++;
            $display("FAIL send_timeout: word %h not accepted within 50 cycles", cw);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
        correct_en = 1'b1; codeword_in = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        got_q.delete(); ref_q.delete(); in_cyc_q.delete();
        stall_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
        correct_en = 1'b1; codeword_in = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_chk++;
        if ({out_valid, in_ready, out_codeword, out_data, out_status} !== {1'b0, 1'b1, 8'h00, 4'h0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b ready=%b cw=%h data=%h st=%b, want 0 1 00 0 00",
                     out_valid, in_ready, out_codeword, out_data, out_status);
        end
        n_chk++;
        if ({cnt_corrected, cnt_uncorr, n_cnt_corrected, n_cnt_uncorr} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_counters: corr=%0d unc=%0d ncorr=%0d nunc=%0d, want all 0",
                     cnt_corrected, cnt_uncorr, n_cnt_corrected, n_cnt_uncorr);
        end
    endtask

    task automatic test_clean();
        logic [7:0] w [3];
        w = '{8'h4B, 8'h00, 8'hFF};
        do_reset();
        foreach (w[i]) send(w[i], 1'b1);
        idle(4);
        n_chk++;
        if (stall_cnt != 0) begin
            n_fail++;
            $display("FAIL clean_in_ready: in_ready low %0d cycles, want 0", stall_cnt);
        end
        n_chk++;
        if (got_q.size() != 3) begin
            n_fail++;
            $display("FAIL clean_count: got %0d words, want 3", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            n_chk++;
            if ({got_q[i].cw, got_q[i].data, got_q[i].st} !== {w[i], w[i][3:0], 2'b00}) begin
                n_fail++;
                $display("FAIL clean_word%0d: got cw=%h data=%h st=%b, want cw=%h data=%h st=00",
                         i, got_q[i].cw, got_q[i].data, got_q[i].st, w[i], w[i][3:0]);
            end
            n_chk++;
            if (got_q[i].cyc - in_cyc_q[i] != 2) begin
                n_fail++;
                $display("FAIL clean_latency%0d: got %0d cycles, want 2", i, got_q[i].cyc - in_cyc_q[i]);
            end
        end
        n_chk++;
        if ({cnt_corrected, cnt_uncorr} !== 32'h0) begin
            n_fail++;
            $display("FAIL clean_counters: corr=%0d unc=%0d, want 0 0", cnt_corrected, cnt_uncorr);
        end
    endtask

    task automatic test_correct();
        do_reset();
        send(8'h4F, 1'b1);
        send(8'h5B, 1'b1);
        idle(4);
        n_chk++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL corr_count: got %0d words, want 2", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 2; i++) begin
            n_chk++;
            if ({got_q[i].cw, got_q[i].data, got_q[i].st} !== {8'h4B, 4'hB, 2'b01}) begin
                n_fail++;
                $display("FAIL corr_word%0d: got cw=%h data=%h st=%b, want cw=4b data=b st=01",
                         i, got_q[i].cw, got_q[i].data, got_q[i].st);
            end
        end
        n_chk++;
        if ({cnt_corrected, cnt_uncorr} !== {16'd2, 16'd0}) begin
            n_fail++;
            $display("FAIL corr_counters: corr=%0d unc=%0d, want 2 0", cnt_corrected, cnt_uncorr);
        end
    endtask

    task automatic test_detect();
        got_q.delete();
        send(8'h4F, 1'b0);
        idle(4);
        n_chk++;
        if (got_q.size() != 1 || {got_q[0].cw, got_q[0].data, got_q[0].st} !== {8'h4F, 4'hF, 2'b11}) begin
            n_fail++;
            $display("FAIL detect_word: got %0d words, first cw=%h st=%b, want 1 word cw=4f st=11",
                     got_q.size(), got_q.size() ? got_q[0].cw : 8'hxx, got_q.size() ? got_q[0].st : 2'bxx);
        end
        n_chk++;
        if ({cnt_corrected, cnt_uncorr, n_cnt_corrected, n_cnt_uncorr} !== {16'd3, 16'd0, 2'd3, 2'd0}) begin
            n_fail++;
            $display("FAIL detect_counters: corr=%0d unc=%0d ncorr=%0d nunc=%0d, want 3 0 3 0",
                     cnt_corrected, cnt_uncorr, n_cnt_corrected, n_cnt_uncorr);
        end
    endtask

    task automatic test_double();
        got_q.delete();
        send(8'h48, 1'b1);
        idle(4);
        n_chk++;
        if (got_q.size() != 1 || {got_q[0].cw, got_q[0].data, got_q[0].st} !== {8'h48, 4'h8, 2'b10}) begin
            n_fail++;
            $display("FAIL double_word: got %0d words, first cw=%h st=%b, want 1 word cw=48 st=10",
                     got_q.size(), got_q.size() ? got_q[0].cw : 8'hxx, got_q.size() ? got_q[0].st : 2'bxx);
        end
        n_chk++;
        if ({cnt_corrected, cnt_uncorr, n_cnt_corrected, n_cnt_uncorr} !== {16'd3, 16'd1, 2'd3, 2'd1}) begin
            n_fail++;
            $display("FAIL double_counters: corr=%0d unc=%0d ncorr=%0d nunc=%0d, want 3 1 3 1",
                     cnt_corrected, cnt_uncorr, n_cnt_corrected, n_cnt_uncorr);
        end
    endtask

    task automatic test_ce_switch();
        do_reset();
        send(8'h4F, 1'b1);
        send(8'h4F, 1'b0);
        correct_en = 1'b1;
        idle(4);
        n_chk++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL ce_count: got %0d words, want 2", got_q.size());
        end else begin
            n_chk++;
            if ({got_q[0].cw, got_q[0].st, got_q[1].cw, got_q[1].st} !== {8'h4B, 2'b01, 8'h4F, 2'b11}) begin
                n_fail++;
                $display("FAIL ce_words: got %h/%b %h/%b, want 4b/01 4f/11",
                         got_q[0].cw, got_q[0].st, got_q[1].cw, got_q[1].st);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w [4];
        logic [9:0] snap;
        int base, idx;
        w = '{8'h4B, 8'h4F, 8'h48, 8'h5B};
        do_reset();
        base = in_cnt;
        idx = 0;
        snap = '0;
        out_ready = 1'b0;
        correct_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            codeword_in = w[idx < 4 ? idx : 0];
            tick();
            idx = in_cnt - base;
            if (k == 2) snap = {out_codeword, out_status};
        end
        n_chk++;
        if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall: accepted=%0d in_ready=%b out_valid=%b, want 2 0 1", idx, in_ready, out_valid);
        end
        n_chk++;
        if ({out_codeword, out_status} !== snap || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_hold: cw/st=%h now %h, delivered=%0d, want stable and 0",
                     snap, {out_codeword, out_status}, got_q.size());
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            in_valid = 1'b1;
            codeword_in = w[idx];
            tick();
            idx = in_cnt - base;
        end
        idle(4);
        n_chk++;
        if (got_q.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words, want 4", got_q.size());
        end else begin
            n_chk++;
            if ({got_q[0].cw, got_q[0].st, got_q[1].cw, got_q[1].st, got_q[2].cw, got_q[2].st, got_q[3].cw, got_q[3].st}
                !== {8'h4B, 2'b00, 8'h4B, 2'b01, 8'h48, 2'b10, 8'h4B, 2'b01}) begin
                n_fail++;
                $display("FAIL bp_order: got %h/%b %h/%b %h/%b %h/%b, want 4b/00 4b/01 48/10 4b/01",
                         got_q[0].cw, got_q[0].st, got_q[1].cw, got_q[1].st,
                         got_q[2].cw, got_q[2].st, got_q[3].cw, got_q[3].st);
            end
        end
    endtask

    task automatic test_saturate_clear();
        logic [7:0] w [5];
        w = '{8'h48, 8'h47, 8'h03, 8'hFC, 8'h88};
        do_reset();
        foreach (w[i]) send(w[i], 1'b1);
        idle(4);
        n_chk++;
        if ({cnt_uncorr, n_cnt_uncorr, n_cnt_corrected} !== {16'd5, 2'd3, 2'd0}) begin
            n_fail++;
            $display("FAIL sat_counters: unc=%0d nunc=%0d ncorr=%0d, want 5 3 0", cnt_uncorr, n_cnt_uncorr, n_cnt_corrected);
        end
        out_ready = 1'b0;
        send(8'h4F, 1'b1);
        for (int k = 0; k < 10 && !out_valid; k++) tick();
        n_chk++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_wait: out_valid=%b, want 1", out_valid);
        end
        clr_cnt = 1'b1;
        out_ready = 1'b1;
        tick();
        clr_cnt = 1'b0;
        n_chk++;
        if (got_q.size() != 6 || {cnt_corrected, cnt_uncorr, n_cnt_corrected, n_cnt_uncorr} !== 36'h0) begin
            n_fail++;
            $display("FAIL clr_priority: delivered=%0d corr=%0d unc=%0d ncorr=%0d nunc=%0d, want 6 0 0 0 0",
                     got_q.size(), cnt_corrected, cnt_uncorr, n_cnt_corrected, n_cnt_uncorr);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send(8'h48, 1'b1);
        idle(3);
        got_q.delete();
        out_ready = 1'b0;
        send(8'h4F, 1'b1);
        send(8'h48, 1'b1);
        n_chk++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || cnt_uncorr !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_fill: out_valid=%b in_ready=%b unc=%0d, want 1 0 1", out_valid, in_ready, cnt_uncorr);
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {cnt_corrected, cnt_uncorr, n_cnt_corrected, n_cnt_uncorr} !== 36'h0) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b corr=%0d unc=%0d, want 0 1 0 0",
                     out_valid, in_ready, cnt_corrected, cnt_uncorr);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        idle(4);
        n_chk++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_discard: %0d words emerged after reset, want 0", got_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] cw;
        int b1, b2, nerr, base, bad;
        do_reset();
        base = in_cnt;
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            cw = encode(4'($urandom_range(0, 15)));
            nerr = $urandom_range(0, 2);
            b1 = $urandom_range(0, 7);
            b2 = (b1 + $urandom_range(1, 7)) % 8;
            if (nerr > 0) cw = cw ^ (8'(1) << b1);
            if (nerr > 1) cw = cw ^ (8'(1) << b2);
            codeword_in = cw;
            in_valid = $urandom_range(0, 3) != 0;
            correct_en = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            clr_cnt = $urandom_range(0, 59) == 0;
            tick();
            n_chk++;
            if (cnt_corrected !== 16'(m_corr) || cnt_uncorr !== 16'(m_unc) ||
                n_cnt_corrected !== sat3(m_corr) || n_cnt_uncorr !== sat3(m_unc)) begin
                n_fail++;
                if (bad++ < 5)
                    $display("FAIL rand_counters cycle %0d: corr=%0d unc=%0d ncorr=%0d nunc=%0d, want %0d %0d %0d %0d",
                             k, cnt_corrected, cnt_uncorr, n_cnt_corrected, n_cnt_uncorr,
                             m_corr, m_unc, sat3(m_corr), sat3(m_unc));
            end
        end
        clr_cnt = 1'b0;
        out_ready = 1'b1;
        idle(6);
        n_chk++;
        if (got_q.size() != in_cnt - base || ref_q.size() != got_q.size() || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: delivered=%0d accepted=%0d matched=%0d pending=%0d",
                     got_q.size(), in_cnt - base, ref_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
            n_chk++;
            if ({got_q[i].cw, got_q[i].data, got_q[i].st} !== {ref_q[i].cw, ref_q[i].data, ref_q[i].st}) begin
                n_fail++;
                if (bad++ < 5)
                    $display("FAIL rand_word%0d: got cw=%h data=%h st=%b, want cw=%h data=%h st=%b",
                             i, got_q[i].cw, got_q[i].data, got_q[i].st, ref_q[i].cw, ref_q[i].data, ref_q[i].st);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_correct();
        test_detect();
        test_double();
        test_ce_switch();
        test_backpressure();
        test_saturate_clear();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
